uart_rx_param: RTL and testbench

Parametrised next-generation UART receiver for the colour-sensor serial link, running on clk_3125. It generalises the fixed 8-bit, even-parity receiver:
- configurable data width, bit period, parity mode and stop bits
- framing-error detection and start-bit glitch rejection
- a receive FIFO with valid/ready read handshake, so frames are not lost while the downstream consumer is busy

It keeps the legacy rx_msg/rx_parity/rx_complete outputs and their error-character behaviour.

---
 rtl/uart_rx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (8N1/8E1/8O2...) with start-glitch rejection, framing check and FWFT receive FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around the bit centre.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 14,
   parameter int DATA_BITS = 8,
   parameter int PARITY_MODE = 1,
   parameter int STOP_BITS = 1,
   parameter int FIFO_DEPTH = 4,
   parameter logic [DATA_BITS-1:0] ERR_CHAR = DATA_BITS'('h3F)
) (
   input  logic                          clk_3125,
   input  logic                          rst,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          rx_msg,
   output logic                          rx_parity,
   output logic                          rx_complete,
   output logic                          frame_err,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_BITS-1:0]          out_data,
   output logic [1:0]                    out_flags,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = DATA_BITS + 2;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [CW-1:0] SMP_LO = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] SMP_MID = CW'(CLKS_PER_BIT/2);
   localparam logic [CW-1:0] TICK = CW'(CLKS_PER_BIT/2 + 1);
`else
   localparam logic [CW-1:0] TICK = CW'(CLKS_PER_BIT/2);
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t state, state_n;
   logic rx_s1, rx_s2, armed, sample, tick, bit_end, done, start_det, perr, perr_q;
   logic par_bit, ferr;
   logic [1:0] primed;
   logic [CW-1:0] cnt;
   logic [3:0] bit_cnt;
   logic [DATA_BITS-1:0] shreg;

   // primed marks when rx_s2 holds a real line sample rather than its reset value
   always_ff @(posedge clk_3125 or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         primed <= 2'b00;
         armed <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         primed <= {primed[0], 1'b1};
         if (state_n == START) armed <= 1'b0;
         else if (primed[1] && rx_s2) armed <= 1'b1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic h_lo, h_mid;
   always_ff @(posedge clk_3125 or posedge rst) begin
      if (rst) begin
         h_lo <= 1'b1;
         h_mid <= 1'b1;
      end else begin
         if (cnt == SMP_LO) h_lo <= rx_s2;
         if (cnt == SMP_MID) h_mid <= rx_s2;
      end
   end
   assign sample = (h_lo & h_mid) | (h_lo & rx_s2) | (h_mid & rx_s2);
`else
   assign sample = rx_s2;
`endif

   assign tick = (cnt == TICK);
   assign bit_end = (cnt == LAST);
   assign start_det = armed && !rx_s2;
   assign perr = (PARITY_MODE != 0) && (par_bit != ((^shreg) ^ (PARITY_MODE == 2)));

   always_comb begin
      state_n = state;
      done = 1'b0;
      case (state)
         IDLE:    if (start_det) state_n = START;
         START:   if (tick && sample) state_n = IDLE;
                  else if (bit_end) state_n = DATA;
         DATA:    if (bit_end && bit_cnt == 4'(DATA_BITS - 1))
                     state_n = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:  if (bit_end) state_n = STOP;
         STOP:    if (bit_end && bit_cnt == 4'(STOP_BITS - 1)) begin
                     done = 1'b1;
                     // a start edge already present goes straight to START so back-to-back frames keep phase
                     state_n = start_det ? START : IDLE;
                  end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_3125 or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         par_bit <= 1'b0;
         ferr <= 1'b0;
         perr_q <= 1'b0;
         rx_msg <= '0;
         rx_parity <= 1'b0;
         rx_complete <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE || state_n != state || bit_end) cnt <= '0;
         else cnt <= cnt + CW'(1);
         if (state_n != state) bit_cnt <= '0;
         else if (bit_end) bit_cnt <= bit_cnt + 4'd1;
         if (state == DATA && tick) shreg <= {sample, shreg[DATA_BITS-1:1]};
         if (state == PARITY && tick) par_bit <= sample;
         if (state_n == START && state != START) ferr <= 1'b0;
         else if (state == STOP && tick && !sample) ferr <= 1'b1;
         rx_complete <= done;
         frame_err <= done && ferr;
         if (done) begin
            rx_msg <= perr ? ERR_CHAR : shreg;
            rx_parity <= par_bit;
            perr_q <= perr;
         end
      end
   end

   logic [FW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic pop, push, full;

   assign full = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign pop = out_valid && out_ready;
   assign push = rx_complete && (!full || pop);
   assign out_valid = (fifo_count != '0);
   assign out_data = mem[rd_ptr][DATA_BITS-1:0];
   assign out_flags = mem[rd_ptr][FW-1:DATA_BITS];

   always_ff @(posedge clk_3125) begin
      if (push) mem[wr_ptr] <= {frame_err, perr_q, rx_msg};
   end

   always_ff @(posedge clk_3125 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (rx_complete && !push) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised scoreboard bench for uart_rx_param at default parameters.
module tb_uart_rx_param;
   localparam int C = 14;
   localparam int F = 11;
   localparam int DEPTH = 4;

   logic clk_3125 = 1'b0, rst = 1'b1, rx = 1'b1, out_ready = 1'b0;
   logic [7:0] rx_msg, out_data;
   logic rx_parity, rx_complete, frame_err, out_valid, overflow;
   logic [1:0] out_flags;
   logic [2:0] fifo_count;

   uart_rx_param dut (
      .clk_3125(clk_3125), .rst(rst), .rx(rx),
      .rx_msg(rx_msg), .rx_parity(rx_parity), .rx_complete(rx_complete), .frame_err(frame_err),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk_3125 = ~clk_3125;

   typedef struct {
      int t;
      logic [7:0] msg;
      logic par;
      logic ferr;
      logic perr;
   } exp_t;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int ready_mode = 0;
   exp_t eq[$];
   logic [9:0] mq[$];
   bit ovf_m = 0;

   always @(posedge clk_3125) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Frame model: even parity over the payload; a wrong parity bit yields 0x3F, a low stop bit a framing error
   task automatic send(input logic [7:0] d, input bit flip, input bit stop0, input int gap);
      exp_t e;
      logic [10:0] bits;
      logic p;
      p = (^d) ^ flip;
      e.t = cyc + 3 + F * C;
      e.msg = flip ? 8'h3F : d;
      e.par = p;
      e.ferr = stop0;
      e.perr = flip;
      eq.push_back(e);
      bits = {~stop0, p, d, 1'b0};
      for (int i = 0; i < F; i++) begin
         rx = bits[i];
         repeat (C) @(posedge clk_3125) #1;
      end
      rx = 1'b1;
      repeat (gap) @(posedge clk_3125) #1;
   endtask

   initial begin
      forever begin
         @(posedge clk_3125) #1;
         case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk_3125) begin
      exp_t e;
      bit popm;
      if (rst) begin
         eq.delete();
         mq.delete();
         ovf_m = 0;
         chk("reset rx_msg", rx_msg, 0);
         chk("reset rx_complete", rx_complete, 0);
         chk("reset frame_err", frame_err, 0);
         chk("reset out_valid", out_valid, 0);
         chk("reset fifo_count", fifo_count, 0);
         chk("reset overflow", overflow, 0);
         chk("reset rx_parity", rx_parity, 0);
      end else begin
         chk("out_valid", out_valid, mq.size() != 0);
         chk("fifo_count", fifo_count, mq.size());
         chk("overflow", overflow, ovf_m);
         if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0][7:0]);
            chk("out_flags", out_flags, mq[0][9:8]);
         end
         popm = out_ready && (mq.size() != 0);
         if (popm) void'(mq.pop_front());
         if (rx_complete) begin
            if (eq.size() == 0) chk("unexpected rx_complete", 1, 0);
            else begin
               e = eq.pop_front();
               chk("completion cycle", cyc, e.t);
               chk("rx_msg", rx_msg, e.msg);
               chk("rx_parity", rx_parity, e.par);
               chk("frame_err", frame_err, e.ferr);
               if (mq.size() < DEPTH) mq.push_back({e.ferr, e.perr, e.msg});
               else ovf_m = 1;
            end
         end else begin
            chk("frame_err without completion", frame_err, 0);
            if (eq.size() != 0 && cyc > eq[0].t) begin
               chk("rx_complete missing", 0, 1);
               void'(eq.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      repeat (3) @(posedge clk_3125) #1;
      rst = 1'b0;
      repeat (3) @(posedge clk_3125) #1;

      ready_mode = 2;
      send(8'h41, 0, 0, 5);
      send(8'h41, 1, 0, 5);
      send(8'h55, 0, 1, 5);

      ready_mode = 0;
      for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 0, 0, 0);
      repeat (20) @(posedge clk_3125) #1;
      chk("burst fifo_count", fifo_count, 4);
      chk("burst overflow", overflow, 1);
      ready_mode = 2;
      repeat (10) @(posedge clk_3125) #1;

      rx = 1'b0;
      repeat (5) @(posedge clk_3125) #1;
      rx = 1'b1;
      repeat (30) @(posedge clk_3125) #1;
      send(8'h66, 0, 0, 4);

      ready_mode = 1;
      for (int i = 0; i < 30; i++) begin
         logic [7:0] d;
         bit flip, stop0;
         d = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         stop0 = ($urandom_range(0, 4) == 0);
         send(d, flip, stop0, stop0 ? 3 + $urandom_range(0, 2) : $urandom_range(0, 2));
      end
      ready_mode = 2;
      repeat (40) @(posedge clk_3125) #1;

      rx = 1'b0;
      repeat (C * 5) @(posedge clk_3125) #1;
      rst = 1'b1;
      repeat (3) @(posedge clk_3125) #1;
      rst = 1'b0;
      repeat (40) @(posedge clk_3125) #1;
      chk("post-reset rx_msg", rx_msg, 0);
      chk("post-reset out_valid", out_valid, 0);
      chk("post-reset overflow", overflow, 0);
      rx = 1'b1;
      repeat (5) @(posedge clk_3125) #1;
      send(8'h7A, 0, 0, 20);
      chk("pending expectations", eq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
